// File: rtl/top2_rr_scheduler.sv
// Round-robin shares one running top-2 (largest / second-largest distinct) update datapath among NUM_CH sample streams.
// Grant is combinational; per-channel results and upd_valid/upd_ch reflect a handshake one edge later.
module top2_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            clr,
  input  logic [$clog2(NUM_CH)-1:0]    rd_ch,
  output logic [DATA_WIDTH-1:0]        rd_first,
  output logic [DATA_WIDTH-1:0]        rd_second,
  output logic [CNT_WIDTH-1:0]         rd_count,
  output logic                         upd_valid,
  output logic [$clog2(NUM_CH)-1:0]    upd_ch
);
  localparam int CHW = $clog2(NUM_CH);

  logic [DATA_WIDTH-1:0] first_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] second_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_q    [NUM_CH];
  logic [DATA_WIDTH-1:0] first_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] second_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_d    [NUM_CH];
  logic [CHW-1:0]        ptr_q, ptr_d;
  logic                  upd_valid_q;
  logic [CHW-1:0]        upd_ch_q;

  logic [NUM_CH-1:0]     elig;
  logic                  grant_found;
  logic [CHW-1:0]        grant_idx;
  logic [CHW-1:0]        scan;
  logic                  accept;

  assign elig = req_valid & ~clr;

  // First eligible channel at or above the pointer, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = CHW'((int'(ptr_q) + k) % NUM_CH);
      if (!grant_found && elig[scan]) begin
        grant_found = 1'b1;
        grant_idx   = scan;
      end
    end
  end

  assign accept = grant_found & resetn;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  logic [DATA_WIDTH-1:0] g_data, g_first, g_second, upd_first, upd_second;
  logic [CNT_WIDTH-1:0]  g_cnt, upd_cnt;

  // Single shared top-2 update on the granted channel
  always_comb begin
    g_data     = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    g_first    = first_q[grant_idx];
    g_second   = second_q[grant_idx];
    g_cnt      = cnt_q[grant_idx];
    upd_first  = g_first;
    upd_second = g_second;
    if (g_data > g_first) begin
      upd_first  = g_data;
      upd_second = g_first;
    end else if (g_data < g_first && g_data > g_second) begin
      upd_second = g_data;
    end
    upd_cnt = (g_cnt == '1) ? g_cnt : g_cnt + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      first_d[i]  = first_q[i];
      second_d[i] = second_q[i];
      cnt_d[i]    = cnt_q[i];
      if (clr[i]) begin
        first_d[i]  = '0;
        second_d[i] = '0;
        cnt_d[i]    = '0;
      end else if (accept && grant_idx == CHW'(i)) begin
        first_d[i]  = upd_first;
        second_d[i] = upd_second;
        cnt_d[i]    = upd_cnt;
      end
    end
  end

  assign ptr_d = accept ? ((int'(grant_idx) == NUM_CH-1) ? '0 : grant_idx + 1'b1) : ptr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        first_q[i]  <= '0;
        second_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ptr_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      first_q     <= first_d;
      second_q    <= second_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      upd_valid_q <= accept;
      if (accept) upd_ch_q <= grant_idx;
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_ch    = upd_ch_q;

  // Out-of-range selects match no channel and read as zero
  always_comb begin
    rd_first  = '0;
    rd_second = '0;
    rd_count  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CHW'(i)) begin
        rd_first  = first_q[i];
        rd_second = second_q[i];
        rd_count  = cnt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_top2_rr_scheduler.sv
// Bench for top2_rr_scheduler: directed vectors, expected updates queued and checked by a monitor on upd_valid.
module tb_top2_rr_scheduler;
  logic         clk;
  logic         resetn;
  logic [3:0]   req_valid, req_ready, clr;
  logic [127:0] req_data;
  logic [1:0]   rd_ch, stim_rd_ch, mon_rd_ch, upd_ch;
  logic         mon_active;
  logic [31:0]  rd_first, rd_second;
  logic [7:0]   rd_count;
  logic         upd_valid;

  logic         s_resetn;
  logic [3:0]   s_req_valid, s_req_ready, s_clr;
  logic [127:0] s_req_data;
  logic [1:0]   s_rd_ch, s_upd_ch;
  logic [31:0]  s_rd_first, s_rd_second;
  logic [1:0]   s_rd_count;
  logic         s_upd_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] f;
    logic [31:0] s;
    logic [7:0]  c;
  } exp_t;
  exp_t sb_q[$];

  assign rd_ch = mon_active ? mon_rd_ch : stim_rd_ch;

  top2_rr_scheduler #(.DATA_WIDTH(32), .NUM_CH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .clr(clr), .rd_ch(rd_ch), .rd_first(rd_first),
    .rd_second(rd_second), .rd_count(rd_count), .upd_valid(upd_valid), .upd_ch(upd_ch)
  );

  top2_rr_scheduler #(.DATA_WIDTH(32), .NUM_CH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(s_resetn), .req_valid(s_req_valid), .req_data(s_req_data),
    .req_ready(s_req_ready), .clr(s_clr), .rd_ch(s_rd_ch), .rd_first(s_rd_first),
    .rd_second(s_rd_second), .rd_count(s_rd_count), .upd_valid(s_upd_valid), .upd_ch(s_upd_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Entered at posedge+1; returns at the next posedge+1
  task automatic step(input logic [3:0] v, input logic [3:0] c, input logic [127:0] d,
                      input logic [3:0] exp_rdy, input logic [31:0] ef, es, input logic [7:0] ec);
    exp_t e;
    req_valid = v;
    clr       = c;
    req_data  = d;
    #1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'd0) begin
      e.ch = oh_idx(exp_rdy);
      e.f  = ef;
      e.s  = es;
      e.c  = ec;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [1:0] ch, input logic [31:0] ef, es, input logic [7:0] ec);
    stim_rd_ch = ch;
    #1;
    chk($sformatf("rd_first ch%0d", ch), rd_first, ef);
    chk($sformatf("rd_second ch%0d", ch), rd_second, es);
    chk($sformatf("rd_count ch%0d", ch), {24'd0, rd_count}, {24'd0, ec});
  endtask

  // Monitor: one queued expectation per upd_valid pulse
  initial begin
    exp_t e;
    mon_active = 1'b0;
    mon_rd_ch  = 2'd0;
    forever begin
      @(negedge clk);
      if (upd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update actual_ch=%0d required=none", upd_ch);
        end else begin
          e = sb_q.pop_front();
          chk("upd_ch", {30'd0, upd_ch}, {30'd0, e.ch});
          mon_rd_ch  = e.ch;
          mon_active = 1'b1;
          #1;
          chk($sformatf("upd_first ch%0d", e.ch), rd_first, e.f);
          chk($sformatf("upd_second ch%0d", e.ch), rd_second, e.s);
          chk($sformatf("upd_count ch%0d", e.ch), {24'd0, rd_count}, {24'd0, e.c});
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    resetn      = 1'b0;
    req_valid   = 4'b1111;
    clr         = 4'd0;
    req_data    = pk(1, 2, 3, 4);
    stim_rd_ch  = 2'd0;
    s_resetn    = 1'b0;
    s_req_valid = 4'd0;
    s_clr       = 4'd0;
    s_req_data  = '0;
    s_rd_ch     = 2'd2;

    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
    chk("upd_valid_reset", {31'd0, upd_valid}, 32'd0);
    resetn    = 1'b1;
    s_resetn  = 1'b1;
    req_valid = 4'd0;
    #1;
    chk("ready_idle", {28'd0, req_ready}, 32'd0);
    for (int ch = 0; ch < 4; ch++) rd_chk(2'(ch), 0, 0, 0);
    @(posedge clk);
    #1;

    // Channel 0 alone: 5, 9, 9, 3, 7
    step(4'b0001, 4'd0, pk(5, 0, 0, 0), 4'b0001, 5, 0, 1);
    step(4'b0001, 4'd0, pk(9, 0, 0, 0), 4'b0001, 9, 5, 2);
    step(4'b0001, 4'd0, pk(9, 0, 0, 0), 4'b0001, 9, 5, 3);
    step(4'b0001, 4'd0, pk(3, 0, 0, 0), 4'b0001, 9, 5, 4);
    step(4'b0001, 4'd0, pk(7, 0, 0, 0), 4'b0001, 9, 7, 5);
    // Pointer 1 -> ch3 only, brings pointer back to 0
    step(4'b1000, 4'd0, pk(0, 0, 0, 4), 4'b1000, 4, 0, 1);
    // Clear ch0 and ch3 with nothing valid
    step(4'b0000, 4'b1001, pk(0, 0, 0, 0), 4'b0000, 0, 0, 0);
    rd_chk(2'd0, 0, 0, 0);
    rd_chk(2'd3, 0, 0, 0);

    // All channels valid for 8 cycles
    step(4'b1111, 4'd0, pk(100, 10, 7, 32'h8000_0000), 4'b0001, 100, 0, 1);
    step(4'b1111, 4'd0, pk(100, 10, 7, 32'h8000_0000), 4'b0010, 10, 0, 1);
    step(4'b1111, 4'd0, pk(100, 10, 7, 32'h8000_0000), 4'b0100, 7, 0, 1);
    step(4'b1111, 4'd0, pk(100, 10, 7, 32'h8000_0000), 4'b1000, 32'h8000_0000, 0, 1);
    step(4'b1111, 4'd0, pk(50, 20, 7, 32'hFFFF_FFFF), 4'b0001, 100, 50, 2);
    step(4'b1111, 4'd0, pk(50, 20, 7, 32'hFFFF_FFFF), 4'b0010, 20, 10, 2);
    step(4'b1111, 4'd0, pk(50, 20, 7, 32'hFFFF_FFFF), 4'b0100, 7, 0, 2);
    step(4'b1111, 4'd0, pk(50, 20, 7, 32'hFFFF_FFFF), 4'b1000, 32'hFFFF_FFFF, 32'h8000_0000, 2);

    // ch1 equal to S moves pointer to 2; then only ch1/ch3 valid -> 3,1,3
    step(4'b0010, 4'd0, pk(0, 10, 0, 0), 4'b0010, 20, 10, 3);
    step(4'b1010, 4'd0, pk(0, 10, 0, 5), 4'b1000, 32'hFFFF_FFFF, 32'h8000_0000, 3);
    step(4'b1010, 4'd0, pk(0, 10, 0, 5), 4'b0010, 20, 10, 4);
    step(4'b1010, 4'd0, pk(0, 10, 0, 32'h8000_0000), 4'b1000, 32'hFFFF_FFFF, 32'h8000_0000, 4);

    // Clear ch1 while it requests: ch2 wins instead
    step(4'b0110, 4'b0010, pk(0, 55, 9, 0), 4'b0100, 9, 7, 3);
    rd_chk(2'd1, 0, 0, 0);
    step(4'b0000, 4'd0, pk(0, 0, 0, 0), 4'b0000, 0, 0, 0);
    // Pointer at 3: ch1 reached after wrap, counting from zero again
    step(4'b0010, 4'd0, pk(0, 3, 0, 0), 4'b0010, 3, 0, 1);
    step(4'b0000, 4'd0, pk(0, 0, 0, 0), 4'b0000, 0, 0, 0);

    // 2-bit counter instance: six samples on ch2 saturate at 3
    for (int k = 1; k <= 6; k++) begin
      s_req_valid = 4'b0100;
      s_req_data  = pk(0, 0, 32'(k), 0);
      #1;
      chk("sat_req_ready", {28'd0, s_req_ready}, 32'h4);
      @(posedge clk);
      #1;
    end
    #1;
    chk("sat_first", s_rd_first, 6);
    chk("sat_second", s_rd_second, 5);
    chk("sat_count", {30'd0, s_rd_count}, 3);
    // Reset mid-stream with ch2 still requesting
    s_req_data = pk(0, 0, 7, 0);
    s_resetn   = 1'b0;
    #1;
    chk("sat_ready_in_reset", {28'd0, s_req_ready}, 0);
    @(posedge clk);
    #1;
    chk("sat_upd_valid_after_reset", {31'd0, s_upd_valid}, 0);
    chk("sat_first_after_reset", s_rd_first, 0);
    chk("sat_second_after_reset", s_rd_second, 0);
    chk("sat_count_after_reset", {30'd0, s_rd_count}, 0);
    s_resetn    = 1'b1;
    s_req_valid = 4'd0;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
